// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: ALU op codes, major opcodes, immediate formats
// and the issue-stage entry layout.
package riscv_pkg;

  localparam int unsigned Xlen = 32;

  localparam logic [3:0] AluAnd  = 4'b0000;
  localparam logic [3:0] AluOr   = 4'b0001;
  localparam logic [3:0] AluAdd  = 4'b0010;
  localparam logic [3:0] AluXor  = 4'b0011;
  localparam logic [3:0] AluSll  = 4'b0100;
  localparam logic [3:0] AluSrl  = 4'b0101;
  localparam logic [3:0] AluSub  = 4'b0110;
  localparam logic [3:0] AluSltu = 4'b0111;
  localparam logic [3:0] AluSlt  = 4'b1000;
  localparam logic [3:0] AluSra  = 4'b1001;

  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} occ_e;

  typedef struct packed {
    logic [3:0]      alu_op;
    logic [Xlen-1:0] ina;
    logic [Xlen-1:0] inb;
    logic [Xlen-1:0] store_data;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic            illegal;
  } issue_t;

  function automatic logic [31:0] imm_i(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[31:25], inst[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] inst);
    return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] inst);
    return {inst[31:12], 12'b0};
  endfunction

  // Base funct3 mapping shared by OP and OP-IMM (funct7 variants handled by caller).
  function automatic logic [3:0] f3_alu_op(input logic [2:0] f3);
    logic [3:0] op;
    case (f3)
      3'b000:  op = AluAdd;
      3'b001:  op = AluSll;
      3'b010:  op = AluSlt;
      3'b011:  op = AluSltu;
      3'b100:  op = AluXor;
      3'b101:  op = AluSrl;
      3'b110:  op = AluOr;
      default: op = AluAnd;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational decode of an instruction into ALU op code and operands.
// Undecodable instructions produce op AND with zero operands and illegal set.
module alu_decode
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = Xlen
) (
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic [3:0]      alu_op,
  output logic [XLEN-1:0] ina,
  output logic [XLEN-1:0] inb,
  output logic            illegal
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;

  assign opcode = inst[6:0];
  assign f3     = inst[14:12];
  assign f7     = inst[31:25];

  always_comb begin
    alu_op  = AluAdd;
    ina     = rs1;
    inb     = rs2;
    illegal = 1'b0;
    case (opcode)
      OpcOp: begin
        if (f7 == 7'h00)                      alu_op = f3_alu_op(f3);
        else if (f7 == 7'h20 && f3 == 3'b000) alu_op = AluSub;
        else if (f7 == 7'h20 && f3 == 3'b101) alu_op = AluSra;
        else                                  illegal = 1'b1;
      end
      OpcOpImm: begin
        alu_op = f3_alu_op(f3);
        inb    = XLEN'(imm_i(inst));
        if (f3 == 3'b001 && f7 != 7'h00) illegal = 1'b1;
        if (f3 == 3'b101) begin
          if (f7 == 7'h20)      alu_op  = AluSra;
          else if (f7 != 7'h00) illegal = 1'b1;
        end
      end
      OpcLoad:  inb = XLEN'(imm_i(inst));
      OpcStore: inb = XLEN'(imm_s(inst));
      OpcBranch: begin
        case (f3)
          3'b000, 3'b001: alu_op = AluSub;
          3'b100, 3'b101: alu_op = AluSlt;
          3'b110, 3'b111: alu_op = AluSltu;
          default:        illegal = 1'b1;
        endcase
      end
      OpcLui: begin
        ina = '0;
        inb = XLEN'(imm_u(inst));
      end
      OpcAuipc: begin
        ina = pc;
        inb = XLEN'(imm_u(inst));
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      alu_op = AluAnd;
      ina    = '0;
      inb    = '0;
    end
  end

endmodule

// File: rtl/alu_issue.sv
// Issue stage: decodes the incoming instruction and holds results in a two-entry
// skid buffer (main drives the outputs, skid absorbs one entry while stalled).
module alu_issue
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = Xlen
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_alu_op,
  output logic [XLEN-1:0] out_ina,
  output logic [XLEN-1:0] out_inb,
  output logic [XLEN-1:0] out_store_data,
  output logic [4:0]      out_rd,
  output logic [2:0]      out_funct3,
  output logic            out_illegal
);

  occ_e   state_q, state_d;
  issue_t main_q, main_d, skid_q, skid_d, dec;
  logic   accept, drain;

  assign accept = in_valid && in_ready;
  assign drain  = out_valid && out_ready;

  alu_decode #(
    .XLEN(XLEN)
  ) u_decode (
    .inst    (in_inst),
    .pc      (in_pc),
    .rs1     (in_rs1),
    .rs2     (in_rs2),
    .alu_op  (dec.alu_op),
    .ina     (dec.ina),
    .inb     (dec.inb),
    .illegal (dec.illegal)
  );

  assign dec.store_data = in_rs2;
  assign dec.rd         = in_inst[11:7];
  assign dec.funct3     = in_inst[14:12];

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= StEmpty;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = StEmpty;
    end else begin
      case (state_q)
        StEmpty: if (accept) state_d = StOne;
        StOne: begin
          if (accept && !drain)      state_d = StTwo;
          else if (!accept && drain) state_d = StEmpty;
        end
        StTwo:   if (drain) state_d = StOne;
        default: state_d = StEmpty;
      endcase
    end
  end

  // Both handshake outputs decode the state register only, so out_ready never
  // reaches in_ready combinationally.
  always_comb begin
    out_valid = (state_q != StEmpty);
    in_ready  = (state_q != StTwo);
  end

  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    case (state_q)
      StEmpty: if (accept) main_d = dec;
      StOne: begin
        if (accept && drain) main_d = dec;
        else if (accept)     skid_d = dec;
      end
      StTwo:   if (drain) main_d = skid_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else if (!flush) begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  assign out_alu_op     = main_q.alu_op;
  assign out_ina        = main_q.ina;
  assign out_inb        = main_q.inb;
  assign out_store_data = main_q.store_data;
  assign out_rd         = main_q.rd;
  assign out_funct3     = main_q.funct3;
  assign out_illegal    = main_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: expected entries queued on accept, checked on
// each output handshake, plus directed handshake/flush/reset checks.
module tb_alu_issue;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] ina;
    logic [31:0] inb;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        ill;
  } exp_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    exp_t        e;
  } stim_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_inst = '0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_rs1 = '0;
  logic [31:0] in_rs2 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  out_alu_op;
  logic [31:0] out_ina, out_inb, out_store_data;
  logic [4:0]  out_rd;
  logic [2:0]  out_funct3;
  logic        out_illegal;

  int    total = 0;
  int    bad = 0;
  exp_t  sb[$];
  exp_t  m_e;
  stim_t tbl[16];

  always #5 clk = ~clk;

  alu_issue dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_inst        (in_inst),
    .in_pc          (in_pc),
    .in_rs1         (in_rs1),
    .in_rs2         (in_rs2),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_alu_op     (out_alu_op),
    .out_ina        (out_ina),
    .out_inb        (out_inb),
    .out_store_data (out_store_data),
    .out_rd         (out_rd),
    .out_funct3     (out_funct3),
    .out_illegal    (out_illegal)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  function automatic stim_t mk(input logic [31:0] inst, pc, rs1, rs2,
                               input logic [3:0] op, input logic [31:0] ina, inb, sd,
                               input logic [4:0] rd, input logic [2:0] f3, input logic ill);
    stim_t s;
    s.inst = inst; s.pc = pc; s.rs1 = rs1; s.rs2 = rs2;
    s.e.op = op; s.e.ina = ina; s.e.inb = inb; s.e.sd = sd;
    s.e.rd = rd; s.e.f3 = f3; s.e.ill = ill;
    return s;
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_out", 32'd1, 32'd0);
      end else begin
        m_e = sb.pop_front();
        check("alu_op", 32'(out_alu_op), 32'(m_e.op));
        check("ina", out_ina, m_e.ina);
        check("inb", out_inb, m_e.inb);
        check("store_data", out_store_data, m_e.sd);
        check("rd", 32'(out_rd), 32'(m_e.rd));
        check("funct3", 32'(out_funct3), 32'(m_e.f3));
        check("illegal", 32'(out_illegal), 32'(m_e.ill));
      end
    end
  end

  // Presents one entry and queues its expectation at the negedge before the accepting edge.
  task automatic send(input stim_t s);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_inst  = s.inst;
    in_pc    = s.pc;
    in_rs1   = s.rs1;
    in_rs2   = s.rs2;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(s.e);
        return;
      end
      @(posedge clk); #1;
    end
    check("send_timeout", 32'd1, 32'd0);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    check(tag, 32'(sb.size()), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    tbl[0]  = mk(32'h002081B3, 0, 5, 7, 4'b0010, 5, 7, 7, 3, 0, 0);
    tbl[1]  = mk(32'h4040D093, 0, 32'h80000000, 0, 4'b1001, 32'h80000000, 32'h404, 0, 1, 5, 0);
    tbl[2]  = mk(32'hFFF00093, 0, 0, 0, 4'b0010, 0, 32'hFFFFFFFF, 0, 1, 0, 0);
    tbl[3]  = mk(32'h12345297, 32'h100, 32'h11, 32'h22, 4'b0010, 32'h100, 32'h12345000,
                 32'h22, 5, 5, 0);
    tbl[4]  = mk(32'h0020E063, 0, 9, 3, 4'b0111, 9, 3, 3, 0, 6, 0);
    tbl[5]  = mk(32'h0000007F, 0, 3, 4, 4'b0000, 0, 0, 4, 0, 0, 1);
    tbl[6]  = mk(32'h402081B3, 0, 32'h10, 3, 4'b0110, 32'h10, 3, 3, 3, 0, 0);
    tbl[7]  = mk(32'h0080A103, 0, 32'h1000, 32'h55, 4'b0010, 32'h1000, 8, 32'h55, 2, 2, 0);
    tbl[8]  = mk(32'hFE20AE23, 0, 32'h2000, 32'h12345678, 4'b0010, 32'h2000, 32'hFFFFFFFC,
                 32'h12345678, 5'h1C, 2, 0);
    tbl[9]  = mk(32'hABCDE3B7, 0, 32'h77, 32'h88, 4'b0010, 0, 32'hABCDE000, 32'h88, 7, 6, 0);
    tbl[10] = mk(32'h022081B3, 0, 1, 2, 4'b0000, 0, 0, 2, 3, 0, 1);
    tbl[11] = mk(32'h40409093, 0, 1, 2, 4'b0000, 0, 0, 2, 1, 1, 1);
    tbl[12] = mk(32'h0020A063, 0, 1, 2, 4'b0000, 0, 0, 2, 0, 2, 1);
    tbl[13] = mk(32'h0020A1B3, 0, 32'hFFFFFFFF, 1, 4'b1000, 32'hFFFFFFFF, 1, 1, 3, 2, 0);
    tbl[14] = mk(32'h0040D093, 0, 32'hF0, 0, 4'b0101, 32'hF0, 4, 0, 1, 5, 0);
    tbl[15] = mk(32'h7FF0E093, 0, 32'h1, 0, 4'b0001, 32'h1, 32'h7FF, 0, 1, 6, 0);

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_alu_op", 32'(out_alu_op), 32'd0);
    check("rst_ina", out_ina, 32'd0);
    check("rst_inb", out_inb, 32'd0);
    check("rst_store", out_store_data, 32'd0);

    // Full-rate stream through the table.
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) send(tbl[i]);
    idle();
    wait_drain("stream_drain");

    // Stall: two accepts fill the buffer, then drain in order.
    out_ready = 1'b0;
    send(tbl[0]);
    send(tbl[6]);
    idle();
    check("stall_in_ready", 32'(in_ready), 32'd0);
    check("stall_out_valid", 32'(out_valid), 32'd1);
    check("stall_op", 32'(out_alu_op), 32'(4'b0010));
    @(posedge clk); #1;
    check("stall_hold_ina", out_ina, 32'd5);
    check("stall_hold_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    wait_drain("stall_drain");

    // Flush in TWO with a presented input.
    out_ready = 1'b0;
    send(tbl[3]);
    send(tbl[4]);
    @(posedge clk); #1;
    in_inst = tbl[9].inst; in_valid = 1'b1; flush = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush2_out_valid", 32'(out_valid), 32'd0);
    check("flush2_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    check("flush2_not_captured", 32'(out_valid), 32'd0);

    // Flush in ONE overrides a simultaneous accept.
    send(tbl[1]);
    @(posedge clk); #1;
    check("one_out_valid", 32'(out_valid), 32'd1);
    in_inst = tbl[2].inst; in_valid = 1'b1; flush = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush1_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("flush1_not_captured", 32'(out_valid), 32'd0);

    // Reset pulse while ONE.
    send(tbl[8]);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("pre_rst_ina", out_ina, 32'h2000);
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_ina", out_ina, 32'd0);
    check("mid_rst_inb", out_inb, 32'd0);
    check("mid_rst_store", out_store_data, 32'd0);

    // Random backpressure burst exercising skid transfers.
    fork
      begin
        for (int i = 0; i < 40; i++) send(tbl[$urandom_range(15)]);
        idle();
      end
      begin
        repeat (90) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(1));
        end
        out_ready = 1'b1;
      end
    join
    wait_drain("burst_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule

// File: doc/alu_issue.md
# alu_issue

Decode-to-execute issue stage for the RISC-V core. It takes a decoded-stage instruction word plus register-file operands and PC, and generates the 4-bit ALU operation code and the two ALU operands. These are held in a two-entry skid-buffered pipeline register with valid/ready handshakes on both sides, so it sits directly in front of the ALU's `ALUop`/`ina`/`inb` inputs.

## Interface
- `XLEN`, 32, datapath width
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  reset; synchronous, active-low
- `flush`  in  1  discard all held entries (branch redirect)
- `in_valid`  in  1  upstream entry valid
- `in_ready`  out  1  stage can accept; registered
- `in_inst`  in  32  instruction word
- `in_pc`  in  XLEN  instruction PC
- `in_rs1`, `in_rs2`  in  XLEN  register-file read data
- `out_valid`  out  1  issued entry valid
- `out_ready`  in  1  ALU/EX stage accepts
- `out_alu_op`  out  4  ALU operation code
- `out_ina`, `out_inb`  out  XLEN  ALU operands
- `out_store_data`  out  XLEN  rs2 value passed through for stores
- `out_rd`  out  5  destination register (`inst[11:7]`)
- `out_funct3`  out  3  passed through for branch/load/store sizing
- `out_illegal`  out  1  instruction not decodable by this stage

## Operation
- ALU codes: AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SLTU 0111, SLT 1000, SRA 1001.
- OP (0110011): funct3 selects add/sll/slt/sltu/xor/srl/or/and; funct7 = 0x20 gives SUB (f3 000) or SRA (f3 101); funct7 = 0x20 with any other f3, or funct7 not in {0x00, 0x20} -> illegal. ina = rs1, inb = rs2.
- OP-IMM (0010011): same mapping, inb = I-imm (sign-extended `inst[31:20]`); SLLI needs `inst[31:25]` = 0; SRLI/SRAI select on `inst[30]`, other `inst[31:25]` values illegal; inb for shifts is the raw immediate (ALU uses [4:0]).
- LOAD (0000011): ADD, rs1 + I-imm. STORE (0100011): ADD, rs1 + S-imm; store_data = rs2.
- BRANCH (1100011): f3 000/001 -> SUB; 100/101 -> SLT; 110/111 -> SLTU; 010/011 illegal. ina = rs1, inb = rs2.
- LUI (0110111): ADD, ina = 0, inb = U-imm (`inst[31:12]`, 12 zero bits). AUIPC (0010111): ADD, ina = pc, inb = U-imm.
- Any other opcode: illegal. Illegal entries still flow through with alu_op = 0000, ina = inb = 0, out_illegal = 1.
- Decode is combinational on input; the result is captured on accept (`in_valid && in_ready`).
- Buffer: main entry drives outputs; skid entry captures an accepted input when the main entry is full and not draining.
  - Transfer out happens when `out_valid && out_ready`; if the skid is full, it moves to main in the same cycle.
  - `in_ready` next = skid empty after this cycle's updates.
- States (occupancy): EMPTY -> ONE on accept; ONE -> ONE on accept + drain, -> EMPTY on drain only, -> TWO on accept without drain; TWO -> ONE on drain (in_ready is 0, so no accept).
- `flush`: both entries invalid next cycle; in the same cycle it overrides any accept and any drain (an entry presented with out_valid is still considered taken by downstream if out_ready = 1; the issuer ignores this).

## Timing
- Reset (rst_n low at edge): out_valid = 0, in_ready = 1, all data outputs 0, occupancy EMPTY.
- Latency: accepted in cycle N -> visible on outputs at N+1.
- Throughput: one entry per cycle while out_ready stays high.
- Outputs stable while `out_valid && !out_ready`; no combinational path from out_ready to in_ready.
- Reset asserted mid-operation drops both entries exactly like flush; in_ready returns to 1.

## Structure
- Shared package `riscv_pkg`: ALU op localparams (the codes above), opcode constants, and immediate-format functions (I/S/B/U); the ALU uses the same package.
- Sub-module `alu_decode`: purely combinational, mapping inst/pc/rs1/rs2 to op, ina, inb, illegal. The top-level `alu_issue` holds the skid-buffer control and registers.

## Test plan
- `add x3,x1,x2` (0x002081B3), rs1 = 5, rs2 = 7 -> next cycle op 0010, ina 5, inb 7, rd 3, illegal 0.
- `srai x1,x1,4` (0x4040D093), rs1 = 0x80000000 -> op 1001, inb = 0x404 (low 5 bits = 4); `addi x1,x0,-1` -> inb 0xFFFFFFFF.
- `auipc x5,0x12345` at pc 0x100 -> op 0010, ina 0x100, inb 0x12345000; `bltu` -> op 0111; opcode 0x7F -> illegal 1, op 0000.
- Back-to-back valid with out_ready = 0 for 3 cycles: two entries accepted, in_ready = 0 from the cycle after the second accept; out_ready = 1 -> both drain in order, none lost or duplicated.
- Buffer TWO, assert flush together with in_valid -> next cycle out_valid 0, in_ready 1, the flushed input not captured.
- Reset pulse while ONE -> out_valid 0, outputs 0, in_ready 1 after the edge.
